trig_arm_ctrl: RTL and testbench
================================

TRIG_ARM_CTRL -- requirements
Module: trig_arm_ctrl

Interface
REQ-001 Parameter SHOT_W, default 16: width of shot and timeout counters.
REQ-002 Ports clk (in, 1) and rst (in, 1); one clock domain; rst is synchronous and active-high.
REQ-003 cfg_trig_level_a/b/c (in, 32 each); cfg_param_mul and cfg_param_off (in, 32 each): staged trigger configuration.
REQ-004 cfg_commit (in, 1): single-cycle pulse; copies all cfg_* inputs into shadow registers.
REQ-005 cfg_timeout (in, 32): per-shot arm window in clk cycles; 0 disables the timeout.
REQ-006 cfg_holdoff (in, 32): idle cycles between shots.
REQ-007 cfg_shots (in, SHOT_W): shots per run; 0 means continuous.
REQ-008 start and stop (in, 1 each): single-cycle run controls.
REQ-009 detect_pls_0, detect_pls_1 (in, 1 each) and pulse_tof (in, 32): status from the trigger generator.
REQ-010 trig_enable (out, 1); trig_level_a/b/c, param_mul, param_off (out, 32 each): shadow values driving the trigger generator.
REQ-011 res_valid (out, 1), res_tof (out, 32), res_ack (in, 1): result handshake.
REQ-012 busy (out, 1), shot_cnt (out, SHOT_W), timeout_cnt (out, SHOT_W), overrun (out, 1, sticky).

Function
REQ-013 State machine states: IDLE, ARM, FIRE, HOLDOFF.
REQ-014 IDLE: trig_enable=0; start -> ARM; shot_cnt, timeout_cnt and overrun are cleared on the same edge.
REQ-015 ARM: trig_enable=1; the window counter increments every cycle.
REQ-016 ARM exits: rising edge of detect_pls_1 -> FIRE; window counter == cfg_timeout-1 with cfg_timeout≠0 -> HOLDOFF with timeout_cnt+1 (saturating) and no result.
REQ-017 FIRE: trig_enable stays 1 until detect_pls_1 falls.
REQ-018 FIRE completion, on the falling-edge cycle:
- res_tof <= pulse_tof, res_valid <= 1.
- shot_cnt +1 (saturating).
- -> HOLDOFF, with trig_enable=0 from the next cycle.
REQ-019 If res_valid is still 1 at capture, res_tof is overwritten and overrun is set.
REQ-020 HOLDOFF: trig_enable=0 for exactly cfg_holdoff cycles (0 allowed: 1-cycle pass-through). Then:
- -> IDLE if cfg_shots≠0 and shot_cnt==cfg_shots;
- -> ARM otherwise.
REQ-021 res_valid clears the cycle after res_ack while res_valid=1. When capture and res_ack coincide, capture wins: res_valid stays 1 and overrun is not set.
REQ-022 stop, in any state -> IDLE next cycle with trig_enable=0; pending res_valid is retained. If stop and start coincide in IDLE, stop wins.
REQ-023 cfg_commit updates the shadow registers only in IDLE or HOLDOFF; elsewhere it is ignored. Outputs change one cycle after commit.
REQ-024 Edge detection uses a 1-cycle registered copy of detect_pls_1, cleared whenever trig_enable=0, so a level already high at ARM entry produces no false edge.
REQ-025 busy = (state≠IDLE).
REQ-026 All outputs are registered. Latency from detect_pls_1 fall to res_valid is 1 cycle. Counters compare unsigned 32-bit.

Reset
REQ-027 On rst: state=IDLE, trig_enable=0, all shadow registers=0, res_valid=0, res_tof=0, shot_cnt=0, timeout_cnt=0, overrun=0, edge register=0.
REQ-028 rst mid-run behaves as stop plus a full clear, taking effect on the next edge.

Structure
REQ-029 Package trig_ctrl_pkg holds the state enumeration and SHOT_W default.
REQ-030 One sub-module, trig_cycle_timer: a 32-bit load/count/expire counter, shared by the ARM window and HOLDOFF.

Verification
REQ-031 Single shot:
- Stimulus: cfg_shots=1, cfg_holdoff=4; start; detect_pls_1 high 10 cycles with pulse_tof=0x1234.
- Response: res_tof=0x1234, res_valid 1 cycle after the fall, shot_cnt=1, IDLE after 4 holdoff cycles.
REQ-032 Timeout:
- Stimulus: cfg_timeout=20, no pulses, cfg_shots=2.
- Response: trig_enable high exactly 20 cycles per attempt; timeout_cnt increments per attempt and keeps rearming, since timeouts do not count as shots.
REQ-033 Overrun:
- Stimulus: two shots with no res_ack, pulse_tof 5 then 9.
- Response: res_tof=9, overrun=1.
- Then: one res_ack clears res_valid; overrun stays 1 until the next start.
REQ-034 Commit gating:
- Stimulus: cfg_commit during ARM with cfg_trig_level_a=0x7FFF0000.
- Response: trig_level_a unchanged; the same commit during HOLDOFF updates it one cycle later.
REQ-035 Stop/reset:
- Stimulus: stop during FIRE.
- Response: trig_enable=0 next cycle, no capture, busy=0.
- Stimulus: rst asserted in ARM.
- Response: all REQ-027 values on the next edge.
REQ-036 Continuous/edge:
- Stimulus: cfg_shots=0; detect_pls_1 already high at ARM entry.
- Response: no FIRE until it falls and rises again; the run continues past shot_cnt wrap, saturating at 0xFFFF.

Source files
------------

// File: rtl/trig_ctrl_pkg.sv
// Shared definitions for the trigger arm controller.
//   - trig_state_e : controller state encoding (also exported as a debug port)
//   - SHOT_W_DEF   : default width of the shot and timeout counters
package trig_ctrl_pkg;

  localparam int SHOT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_state_e;

endpackage

// File: rtl/trig_cycle_timer.sv
// 32-bit load/count/expire cycle counter, shared by the ARM window and the
// HOLDOFF interval of the trigger arm controller.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load         : restart the count at zero (wins over en)
//   en           : advance the count by one
//   limit        : window length in cycles
//   expire       : count has reached limit-1 (last cycle of the window)
module trig_cycle_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] limit,
  output logic        expire
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (load) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

  // Unsigned compare; a zero limit wraps to all-ones, which the caller
  // treats separately (disabled timeout / pass-through holdoff).
  assign expire = (count == (limit - 32'd1));

endmodule

// File: rtl/trig_arm_ctrl.sv
// Trigger arm controller: arms a trigger generator, waits for a detected
// pulse (or a window timeout), captures its time of flight, holds off and
// re-arms until the configured number of shots has been taken.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cfg_trig_level_a/b/c,
//   cfg_param_mul/off, cfg_commit : staged generator settings, copied into
//                                   the shadow outputs on cfg_commit while
//                                   IDLE or HOLDOFF
//   cfg_timeout                   : ARM window in cycles, 0 = no timeout
//   cfg_holdoff                   : HOLDOFF length in cycles (0 acts as 1)
//   cfg_shots                     : shots per run, 0 = continuous
//   start, stop                   : single-cycle run controls (stop wins)
//   detect_pls_0/1, pulse_tof     : status from the trigger generator
//   trig_enable, trig_level_*,
//   param_mul/off                 : drive the trigger generator
//   res_valid, res_tof, res_ack   : result handshake
//   busy, shot_cnt, timeout_cnt,
//   overrun                       : run status (overrun is sticky per run)
//   fsm_state                     : current controller state (debug)
//
// Result handshake: res_valid/res_tof are held until res_ack is seen with
// res_valid high, after which res_valid drops on the next cycle. A new
// capture always replaces res_tof; if the previous result was still pending
// and not acknowledged in that same cycle, overrun is raised.
module trig_arm_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int SHOT_W = SHOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cfg_trig_level_a,
  input  logic [31:0]       cfg_trig_level_b,
  input  logic [31:0]       cfg_trig_level_c,
  input  logic [31:0]       cfg_param_mul,
  input  logic [31:0]       cfg_param_off,
  input  logic              cfg_commit,
  input  logic [31:0]       cfg_timeout,
  input  logic [31:0]       cfg_holdoff,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic              start,
  input  logic              stop,
  input  logic              detect_pls_0,
  input  logic              detect_pls_1,
  input  logic [31:0]       pulse_tof,
  output logic              trig_enable,
  output logic [31:0]       trig_level_a,
  output logic [31:0]       trig_level_b,
  output logic [31:0]       trig_level_c,
  output logic [31:0]       param_mul,
  output logic [31:0]       param_off,
  output logic              res_valid,
  output logic [31:0]       res_tof,
  input  logic              res_ack,
  output logic              busy,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic [SHOT_W-1:0] timeout_cnt,
  output logic              overrun,
  output logic [1:0]        fsm_state
);

  localparam logic [SHOT_W-1:0] CNT_ONE = SHOT_W'(1);
  localparam logic [SHOT_W-1:0] CNT_MAX = {SHOT_W{1'b1}};

  trig_state_e state_q, state_d;
  logic        det_q;
  logic        rise, fall;
  logic        capture, timeout_hit, start_run, armed_d;
  logic        tmr_load, tmr_expire;
  logic [31:0] tmr_limit;

  // detect_pls_0 is status only; this controller acts on detect_pls_1.
  logic unused_ok;
  assign unused_ok = detect_pls_0;

  // det_q holds the previous detect_pls_1 sample only while armed. It is
  // primed with the live level on the arming edge, so a pulse that is
  // already high when ARM is entered must fall and rise again to count.
  assign rise = detect_pls_1 & ~det_q;
  assign fall = ~detect_pls_1 & det_q;

  assign tmr_limit = (state_q == ST_HOLDOFF) ? cfg_holdoff : cfg_timeout;
  // Any state change restarts the shared timer for the new window.
  assign tmr_load  = (state_d != state_q);

  trig_cycle_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (1'b1),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (rise) begin
          state_d = ST_FIRE;
        end else if (tmr_expire && (cfg_timeout != 32'd0)) begin
          state_d     = ST_HOLDOFF;
          timeout_hit = 1'b1;
        end
      end
      ST_FIRE: begin
        if (fall) begin
          state_d = ST_HOLDOFF;
          capture = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tmr_expire || (cfg_holdoff == 32'd0)) begin
          if ((cfg_shots != '0) && (shot_cnt == cfg_shots)) state_d = ST_IDLE;
          else                                              state_d = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // stop overrides everything, including a capture on the same cycle.
    if (stop) begin
      state_d     = ST_IDLE;
      capture     = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  assign start_run = (state_q == ST_IDLE) && start && !stop;
  assign armed_d   = (state_d == ST_ARM) || (state_d == ST_FIRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      trig_enable  <= 1'b0;
      busy         <= 1'b0;
      det_q        <= 1'b0;
      trig_level_a <= 32'd0;
      trig_level_b <= 32'd0;
      trig_level_c <= 32'd0;
      param_mul    <= 32'd0;
      param_off    <= 32'd0;
      res_valid    <= 1'b0;
      res_tof      <= 32'd0;
      shot_cnt     <= '0;
      timeout_cnt  <= '0;
      overrun      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_enable <= armed_d;
      busy        <= (state_d != ST_IDLE);
      det_q       <= armed_d ? detect_pls_1 : 1'b0;

      if (cfg_commit && ((state_q == ST_IDLE) || (state_q == ST_HOLDOFF))) begin
        trig_level_a <= cfg_trig_level_a;
        trig_level_b <= cfg_trig_level_b;
        trig_level_c <= cfg_trig_level_c;
        param_mul    <= cfg_param_mul;
        param_off    <= cfg_param_off;
      end

      if (start_run) begin
        shot_cnt    <= '0;
        timeout_cnt <= '0;
        overrun     <= 1'b0;
      end

      if (capture && (shot_cnt != CNT_MAX)) shot_cnt <= shot_cnt + CNT_ONE;
      if (timeout_hit && (timeout_cnt != CNT_MAX)) timeout_cnt <= timeout_cnt + CNT_ONE;

      if (capture) begin
        res_tof   <= pulse_tof;
        res_valid <= 1'b1;
        if (res_valid && !res_ack) overrun <= 1'b1;
      end else if (res_valid && res_ack) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_trig_arm_ctrl.sv
// Self-checking bench for trig_arm_ctrl: directed scenarios followed by
// randomized runs, all compared every cycle against a behavioural model
// that tracks the run as a phase plus a cycles-remaining countdown.
module tb_trig_arm_ctrl;

  // Narrow counters keep the saturation run short.
  localparam int SW = 8;
  localparam int SMAX = (1 << SW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   cfg_trig_level_a, cfg_trig_level_b, cfg_trig_level_c;
  logic [31:0]   cfg_param_mul, cfg_param_off;
  logic          cfg_commit;
  logic [31:0]   cfg_timeout, cfg_holdoff;
  logic [SW-1:0] cfg_shots;
  logic          start, stop;
  logic          detect_pls_0, detect_pls_1;
  logic [31:0]   pulse_tof;
  logic          trig_enable;
  logic [31:0]   trig_level_a, trig_level_b, trig_level_c, param_mul, param_off;
  logic          res_valid, res_ack;
  logic [31:0]   res_tof;
  logic          busy, overrun;
  logic [SW-1:0] shot_cnt, timeout_cnt;
  logic [1:0]    fsm_state;

  trig_arm_ctrl #(.SHOT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .cfg_trig_level_a(cfg_trig_level_a), .cfg_trig_level_b(cfg_trig_level_b),
    .cfg_trig_level_c(cfg_trig_level_c), .cfg_param_mul(cfg_param_mul),
    .cfg_param_off(cfg_param_off), .cfg_commit(cfg_commit),
    .cfg_timeout(cfg_timeout), .cfg_holdoff(cfg_holdoff), .cfg_shots(cfg_shots),
    .start(start), .stop(stop),
    .detect_pls_0(detect_pls_0), .detect_pls_1(detect_pls_1), .pulse_tof(pulse_tof),
    .trig_enable(trig_enable),
    .trig_level_a(trig_level_a), .trig_level_b(trig_level_b), .trig_level_c(trig_level_c),
    .param_mul(param_mul), .param_off(param_off),
    .res_valid(res_valid), .res_tof(res_tof), .res_ack(res_ack),
    .busy(busy), .shot_cnt(shot_cnt), .timeout_cnt(timeout_cnt),
    .overrun(overrun), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // acknowledged results, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 armed waiting, 2 pulse in progress, 3 holdoff
  int          m_phase, m_left, m_shots, m_tos;
  bit          m_prev, m_valid, m_ovr;
  logic [31:0] m_la, m_lb, m_lc, m_mul, m_off, m_tof;

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic model_step();
    bit det, cap;
    det = detect_pls_1;
    cap = 0;
    if (rst) begin
      m_phase = 0; m_prev = 0; m_valid = 0; m_ovr = 0; m_tof = 0;
      m_shots = 0; m_tos = 0;
      m_la = 0; m_lb = 0; m_lc = 0; m_mul = 0; m_off = 0;
      exp_q.delete();
      return;
    end
    if (cfg_commit && (m_phase == 0 || m_phase == 3)) begin
      m_la = cfg_trig_level_a; m_lb = cfg_trig_level_b; m_lc = cfg_trig_level_c;
      m_mul = cfg_param_mul; m_off = cfg_param_off;
    end
    if (m_valid && res_ack) exp_q.push_back(m_tof);
    if (stop) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_left = int'(cfg_timeout);
             m_shots = 0; m_tos = 0; m_ovr = 0;
           end
        1: if (det && !m_prev) m_phase = 2;
           else if (cfg_timeout != 0 && m_left == 1) begin
             m_tos++; m_phase = 3;
             m_left = (cfg_holdoff == 0) ? 1 : int'(cfg_holdoff);
           end else m_left--;
        2: if (!det) begin
             cap = 1; m_shots++; m_phase = 3;
             m_left = (cfg_holdoff == 0) ? 1 : int'(cfg_holdoff);
           end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (cfg_shots != 0 && sat(m_shots) == int'(cfg_shots)) m_phase = 0;
            else begin m_phase = 1; m_left = int'(cfg_timeout); end
          end
        end
      endcase
    end
    if (cap) begin
      if (m_valid && !res_ack) m_ovr = 1;
      m_valid = 1; m_tof = pulse_tof;
    end else if (m_valid && res_ack) begin
      m_valid = 0;
    end
    m_prev = (m_phase == 1 || m_phase == 2) ? det : 1'b0;
  endtask

  task automatic compare_all();
    check("trig_enable", trig_enable, (m_phase == 1 || m_phase == 2));
    check("busy", busy, (m_phase != 0));
    check("res_valid", res_valid, m_valid);
    check("res_tof", res_tof, m_tof);
    check("shot_cnt", shot_cnt, sat(m_shots));
    check("timeout_cnt", timeout_cnt, sat(m_tos));
    check("overrun", overrun, m_ovr);
    check("trig_level_a", trig_level_a, m_la);
    check("trig_level_b", trig_level_b, m_lb);
    check("trig_level_c", trig_level_c, m_lc);
    check("param_mul", param_mul, m_mul);
    check("param_off", param_off, m_off);
  endtask

  // ---------------- driver tasks ----------------
  // Called at the falling edge with inputs set; advances one clock.
  task automatic tick();
    if (!rst && res_valid && res_ack) begin
      model_step();
      check("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("sb_tof", res_tof, exp_q.pop_front());
    end else begin
      model_step();
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
    start = 0; stop = 0; cfg_commit = 0; res_ack = 0; rst = 0;
  endtask

  task automatic set_cfg(input int t, input int h, input int s);
    cfg_timeout = t; cfg_holdoff = h; cfg_shots = SW'(s);
  endtask

  task automatic shot(input logic [31:0] tof, input int len);
    detect_pls_1 = 1; pulse_tof = tof;
    repeat (len) tick();
    detect_pls_1 = 0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1; start = 0; stop = 0; cfg_commit = 0; res_ack = 0;
    cfg_trig_level_a = 0; cfg_trig_level_b = 0; cfg_trig_level_c = 0;
    cfg_param_mul = 0; cfg_param_off = 0;
    cfg_timeout = 0; cfg_holdoff = 0; cfg_shots = 0;
    detect_pls_0 = 0; detect_pls_1 = 0; pulse_tof = 0;
    m_phase = 0; m_left = 0; m_shots = 0; m_tos = 0; m_prev = 0;
    m_valid = 0; m_ovr = 0; m_tof = 0;
    m_la = 0; m_lb = 0; m_lc = 0; m_mul = 0; m_off = 0;
    @(negedge clk);
    rst = 1; tick();
    check("rst_busy", busy, 1'b0);
    check("rst_trig", trig_enable, 1'b0);

    // single shot
    set_cfg(0, 4, 1);
    start = 1; tick();
    tick(); tick();
    detect_pls_1 = 1; pulse_tof = 32'h1234;
    repeat (10) tick();
    detect_pls_1 = 0; tick();
    check("ss_valid", res_valid, 1'b1);
    check("ss_tof", res_tof, 32'h1234);
    check("ss_shots", shot_cnt, 1);
    check("ss_trig_off", trig_enable, 1'b0);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("ss_hold_len", n, 4);
    res_ack = 1; tick();
    check("ss_ack", res_valid, 1'b0);

    // timeout, re-arming without counting shots
    set_cfg(20, 2, 2);
    start = 1; tick();
    for (int a = 1; a <= 2; a++) begin
      n = 0;
      while (trig_enable && n < 100) begin tick(); n++; end
      check("to_window", n, 20);
      check("to_cnt", timeout_cnt, a);
      check("to_shots", shot_cnt, 0);
      n = 0;
      while (!trig_enable && n < 10) begin tick(); n++; end
      check("to_hold", n, 2);
    end
    stop = 1; tick();
    check("to_stop_busy", busy, 1'b0);

    // overrun
    set_cfg(0, 1, 2);
    start = 1; tick();
    tick();
    shot(32'd5, 3);
    tick();
    shot(32'd9, 3);
    check("ov_tof", res_tof, 32'd9);
    check("ov_flag", overrun, 1'b1);
    tick();
    res_ack = 1; tick();
    check("ov_ack_valid", res_valid, 1'b0);
    check("ov_sticky", overrun, 1'b1);
    tick(); tick();
    check("ov_sticky2", overrun, 1'b1);
    start = 1; tick();
    check("ov_clr", overrun, 1'b0);
    stop = 1; tick();

    // commit gating
    set_cfg(0, 10, 0);
    cfg_trig_level_a = 32'h7FFF0000; cfg_trig_level_b = $urandom;
    cfg_trig_level_c = $urandom; cfg_param_mul = $urandom; cfg_param_off = $urandom;
    start = 1; tick();
    tick();
    cfg_commit = 1; tick();
    check("cg_arm_a", trig_level_a, 32'h0);
    shot(32'hAA, 2);
    cfg_commit = 1; tick();
    check("cg_hold_a", trig_level_a, 32'h7FFF0000);
    stop = 1; tick();
    res_ack = 1; tick();

    // stop during FIRE, then reset during ARM
    set_cfg(0, 3, 0);
    start = 1; tick();
    detect_pls_1 = 1; tick();
    tick();
    detect_pls_1 = 0; stop = 1; tick();
    check("sp_trig", trig_enable, 1'b0);
    check("sp_busy", busy, 1'b0);
    check("sp_nocap", res_valid, 1'b0);
    check("sp_shots", shot_cnt, 0);
    start = 1; tick();
    tick();
    rst = 1; tick();
    check("rs_busy", busy, 1'b0);
    check("rs_level_a", trig_level_a, 32'h0);
    check("rs_trig", trig_enable, 1'b0);

    // continuous run, level already high at arming, saturation
    set_cfg(0, 0, 0);
    detect_pls_1 = 1; pulse_tof = 32'h55;
    start = 1; tick();
    repeat (5) tick();
    detect_pls_1 = 0; tick();
    check("ed_no_fire", shot_cnt, 0);
    check("ed_no_res", res_valid, 1'b0);
    detect_pls_1 = 1; tick();
    detect_pls_1 = 0; tick();
    check("ed_fire", shot_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      tick();
      detect_pls_1 = 1; pulse_tof = i; tick();
      detect_pls_1 = 0; tick();
    end
    check("sat_shots", shot_cnt, SMAX);
    check("sat_busy", busy, 1'b1);
    stop = 1; res_ack = 1; tick();

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      stop = 1; tick();
      set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
      start = 1; tick();
      n = $urandom_range(30, 120);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 9) < 3) detect_pls_1 = ~detect_pls_1;
        detect_pls_0 = $urandom_range(0, 1);
        pulse_tof = $urandom;
        res_ack = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) begin
          cfg_commit = 1;
          cfg_trig_level_a = $urandom; cfg_trig_level_b = $urandom;
          cfg_trig_level_c = $urandom; cfg_param_mul = $urandom; cfg_param_off = $urandom;
        end
        stop  = ($urandom_range(0, 49) == 0);
        start = ($urandom_range(0, 9) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        tick();
      end
    end

    check("sb_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
